// File: rtl/rx_sample_buffer_pkg.sv
// Shared constants and types for the RX sample buffer.
// The overflow counter width is used only when RX_SAMPLE_BUFFER_OVF_CNT_EN is defined.
package rx_sample_buffer_pkg;

  localparam int DATA_W_DEF = 32;

  // Samples are packed as {I, Q}.
  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

  localparam int OVF_CNT_W = 16;

  typedef struct packed {
    logic signed [I_MSB-I_LSB:0] i;
    logic signed [Q_MSB-Q_LSB:0] q;
  } iq_sample_t;

endpackage

// File: rtl/rx_sample_buffer_if.sv
// Groups the upstream AXI-Stream sample input and the bus-side pop port.
// The slave modport is the buffer side; the master modport is the RX chain and bus side.
interface rx_sample_buffer_if #(
  parameter int DATA_W = 32
);
  logic              axis_tvalid_i;
  logic [DATA_W-1:0] axis_tdata_i;
  logic              axis_tready_o;
  logic              rd_en_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;

  modport slave (
    input  axis_tvalid_i, axis_tdata_i, rd_en_i,
    output axis_tready_o, rd_data_o, rd_valid_o
  );

  modport master (
    output axis_tvalid_i, axis_tdata_i, rd_en_i,
    input  axis_tready_o, rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/rx_sample_buffer_ram.sv
// Simple dual-port sample storage: one write port and one registered read port.
// The array itself is never reset; only the read register is, so the popped-data output starts at zero.
module rx_sample_buffer_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read register holds its value between pops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_sample_buffer.sv
// FIFO between the RX chain (AXI-Stream in) and a bus reader (pop on rd_en_i).
// Optional sticky-overflow counter output when RX_SAMPLE_BUFFER_OVF_CNT_EN is defined.
module rx_sample_buffer
  import rx_sample_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rx_sample_buffer_if.slave     bus,
  input  logic                  clr_overflow_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o
`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]  ovf_count_o
`endif
);

  localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, full_q;
  logic                  rd_valid_q;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, drop;
  logic [DATA_W-1:0]     rd_data;

  // Accept/drop decisions look only at registered full/empty, so tready never depends on rd_en_i.
  always_comb begin
    push       = bus.axis_tvalid_i && !full_q;
    drop       = bus.axis_tvalid_i && full_q;
    pop        = bus.rd_en_i && !empty_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == DEPTH);
      rd_valid_q <= pop;
      overflow_q <= overflow_d;
    end
  end

  // A pop never targets the slot being written: pop needs !empty, write needs !full.
  rx_sample_buffer_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.axis_tdata_i),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign bus.axis_tready_o = !full_q;
  assign bus.rd_data_o     = rd_data;
  assign bus.rd_valid_o    = rd_valid_q;
  assign count_o           = count_q;
  assign empty_o           = empty_q;
  assign full_o            = full_q;
  assign overflow_o        = overflow_q;

`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
  localparam logic [OVF_CNT_W-1:0] OVF_ONE = 1;

  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + OVF_ONE;
  endfunction

  // A clear in the same cycle as a drop restarts the count at one.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      ovf_cnt_d = clr_overflow_i ? OVF_ONE : sat_inc(ovf_cnt_q);
    end else if (clr_overflow_i) begin
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rx_sample_buffer.sv
// Directed bench for rx_sample_buffer at DEPTH_LOG2=4; overflow-counter checks
// are included when RX_SAMPLE_BUFFER_OVF_CNT_EN is defined.
module tb_rx_sample_buffer;

  logic        clk;
  logic        rst_n;
  logic        clr_overflow;
  logic [4:0]  count;
  logic        empty, full, overflow;
`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;

  rx_sample_buffer_if #(.DATA_W(32)) bus_if ();

  rx_sample_buffer #(
    .DEPTH_LOG2 (4),
    .DATA_W     (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus_if.slave),
    .clr_overflow_i (clr_overflow),
    .count_o        (count),
    .empty_o        (empty),
    .full_o         (full),
    .overflow_o     (overflow)
`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
    ,
    .ovf_count_o    (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.axis_tvalid_i = 1'b0;
    bus_if.axis_tdata_i  = '0;
    bus_if.rd_en_i       = 1'b0;
    clr_overflow         = 1'b0;
  endtask

  logic [31:0] exp_data;

  initial begin
    // Reset
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tready", bus_if.axis_tready_o, 1);
    chk("rst_rd_valid", bus_if.rd_valid_o, 0);
    chk("rst_rd_data", bus_if.rd_data_o, 0);
    chk("rst_overflow", overflow, 0);
`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
    chk("rst_ovf_count", ovf_count, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Fill with 16 samples, no reads
    for (int i = 0; i < 16; i++) begin
      bus_if.axis_tvalid_i = 1'b1;
      bus_if.axis_tdata_i  = 32'h0001_0000 + 32'(i);
      tick();
      chk("fill_count", count, 64'(i + 1));
    end
    idle_inputs();
    chk("fill_full", full, 1);
    chk("fill_tready", bus_if.axis_tready_o, 0);
    chk("fill_empty", empty, 0);

    // Push into a full buffer: dropped
    bus_if.axis_tvalid_i = 1'b1;
    bus_if.axis_tdata_i  = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    chk("drop_overflow", overflow, 1);
    chk("drop_count", count, 16);
`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
    chk("drop_ovf_count", ovf_count, 1);
`endif

    // Drain 16 in order; DEADBEEF must not appear
    for (int i = 0; i < 16; i++) begin
      bus_if.rd_en_i = 1'b1;
      tick();
      exp_data = 32'h0001_0000 + 32'(i);
      chk("drain_valid", bus_if.rd_valid_o, 1);
      chk("drain_data", bus_if.rd_data_o, 64'(exp_data));
    end
    bus_if.rd_en_i = 1'b0;
    tick();
    chk("drain_valid_drop", bus_if.rd_valid_o, 0);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_overflow_sticky", overflow, 1);

    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_overflow", overflow, 0);
`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
    chk("clr_ovf_count", ovf_count, 0);
`endif

    // Read while empty: no pop, data held
    bus_if.rd_en_i = 1'b1;
    tick();
    chk("empty_rd_valid", bus_if.rd_valid_o, 0);
    chk("empty_rd_data_hold", bus_if.rd_data_o, 32'h0001_000F);
    chk("empty_rd_count", count, 0);

    // Empty: write and read together -> write only
    bus_if.axis_tvalid_i = 1'b1;
    bus_if.axis_tdata_i  = 32'hA5A5_0001;
    tick();
    bus_if.axis_tvalid_i = 1'b0;
    chk("empty_wr_rd_count", count, 1);
    chk("empty_wr_rd_valid", bus_if.rd_valid_o, 0);
    chk("empty_wr_rd_empty", empty, 0);
    tick();
    bus_if.rd_en_i = 1'b0;
    chk("empty_wr_rd_pop_valid", bus_if.rd_valid_o, 1);
    chk("empty_wr_rd_pop_data", bus_if.rd_data_o, 32'hA5A5_0001);
    chk("empty_wr_rd_pop_count", count, 0);

    // Level 8, then 40 cycles of simultaneous write and read across pointer wrap
    for (int i = 0; i < 8; i++) begin
      bus_if.axis_tvalid_i = 1'b1;
      bus_if.axis_tdata_i  = 32'h0002_0000 + 32'(i);
      tick();
    end
    chk("stream_prefill_count", count, 8);
    for (int c = 0; c < 40; c++) begin
      bus_if.axis_tvalid_i = 1'b1;
      bus_if.axis_tdata_i  = 32'h0002_0008 + 32'(c);
      bus_if.rd_en_i       = 1'b1;
      tick();
      exp_data = 32'h0002_0000 + 32'(c);
      chk("stream_count", count, 8);
      chk("stream_valid", bus_if.rd_valid_o, 1);
      chk("stream_data", bus_if.rd_data_o, 64'(exp_data));
    end
    bus_if.axis_tvalid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_data = 32'h0002_0028 + 32'(i);
      chk("stream_tail_data", bus_if.rd_data_o, 64'(exp_data));
    end
    idle_inputs();
    tick();
    chk("stream_tail_empty", empty, 1);

    // Full: write and read together -> write dropped, pop proceeds
    for (int i = 0; i < 16; i++) begin
      bus_if.axis_tvalid_i = 1'b1;
      bus_if.axis_tdata_i  = 32'h0003_0000 + 32'(i);
      tick();
    end
    chk("refill_full", full, 1);
    bus_if.axis_tdata_i = 32'hBAD0_BAD0;
    bus_if.rd_en_i      = 1'b1;
    tick();
    idle_inputs();
    chk("full_wr_rd_count", count, 15);
    chk("full_wr_rd_overflow", overflow, 1);
    chk("full_wr_rd_valid", bus_if.rd_valid_o, 1);
    chk("full_wr_rd_data", bus_if.rd_data_o, 32'h0003_0000);
    chk("full_wr_rd_tready", bus_if.axis_tready_o, 1);
`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
    chk("full_wr_rd_ovf_count", ovf_count, 1);
`endif

    // Refill, then clear and drop in the same cycle: set wins
    bus_if.axis_tvalid_i = 1'b1;
    bus_if.axis_tdata_i  = 32'h0003_0010;
    tick();
    chk("refill2_full", full, 1);
    bus_if.axis_tdata_i = 32'hBAD1_BAD1;
    clr_overflow        = 1'b1;
    tick();
    idle_inputs();
    chk("clr_drop_overflow", overflow, 1);
    chk("clr_drop_count", count, 16);
`ifdef RX_SAMPLE_BUFFER_OVF_CNT_EN
    chk("clr_drop_ovf_count", ovf_count, 1);
`endif

    // Pop 6 down to level 10, order intact after the drops
    for (int i = 1; i <= 6; i++) begin
      bus_if.rd_en_i = 1'b1;
      tick();
      exp_data = 32'h0003_0000 + 32'(i);
      chk("pre_rst_data", bus_if.rd_data_o, 64'(exp_data));
    end
    bus_if.rd_en_i = 1'b0;
    tick();
    chk("pre_rst_count", count, 10);

    // Reset mid-operation with a read pending
    bus_if.rd_en_i = 1'b1;
    rst_n          = 1'b0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_tready", bus_if.axis_tready_o, 1);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_rd_valid", bus_if.rd_valid_o, 0);
    chk("mid_rst_rd_data", bus_if.rd_data_o, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rd_valid", bus_if.rd_valid_o, 0);
    bus_if.rd_en_i       = 1'b0;
    bus_if.axis_tvalid_i = 1'b1;
    bus_if.axis_tdata_i  = 32'h0000_0077;
    tick();
    idle_inputs();
    bus_if.rd_en_i = 1'b1;
    tick();
    bus_if.rd_en_i = 1'b0;
    chk("post_rst_pop_data", bus_if.rd_data_o, 32'h0000_0077);
    chk("post_rst_pop_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
